mod_inv: RTL and testbench

//  Modular inverse over Z_Q: inv = a^(Q-2) mod Q (Fermat), computed by an FSM doing left-to-right

---
 rtl/mod_inv_if.sv | 22 ++
 rtl/mod_inv.sv | 116 +++++++++++
 tb/tb_mod_inv.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mod_inv_if.sv
// Request/response bundle for the modular inverse unit.
// The requester drives start/a; the inverter returns busy/done/inv/err.
interface mod_inv_if #(
    parameter int WIDTH = 13
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] inv;
    logic             err;

    modport master (
        output start, a,
        input  busy, done, inv, err
    );

    modport slave (
        input  start, a,
        output busy, done, inv, err
    );
endinterface

// File: rtl/mod_inv.sv
// Modular inverse over Z_Q by Fermat's little theorem: inv = a^(Q-2) mod Q.
// A left-to-right square-and-multiply FSM shares one single-cycle a*b mod Q
// multiplier. A zero residue still runs the full exponentiation and flags err.
module mod_inv #(
    parameter int WIDTH = 13,
    parameter int Q     = 7681
) (
    input  logic     clk,
    input  logic     rst,     // asynchronous, active-low
    mod_inv_if.slave bus
);

    localparam int               IW     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] Q_N    = WIDTH'(Q);
    localparam logic [2*WIDTH-1:0] Q_W  = (2*WIDTH)'(Q);
    localparam logic [WIDTH-1:0] EXP    = WIDTH'(Q - 2);
    localparam logic [IW-1:0]    IDX_HI = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   acc;
    logic [IW-1:0]      idx;
    logic [WIDTH-1:0]   inv_q;
    logic               err_q;

    logic [WIDTH-1:0]   a_red;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   prod_red;

    // Since a < 2^WIDTH < 2*Q, one conditional subtraction fully reduces it.
    assign a_red = (bus.a >= Q_N) ? bus.a - Q_N : bus.a;

    // Shared multiplier: squares in SQR, multiplies by the operand in MUL.
    assign mul_b    = (state == MUL) ? a_r : acc;
    assign product  = (2*WIDTH)'(acc) * (2*WIDTH)'(mul_b);
    assign prod_red = WIDTH'(product % Q_W);

    // State register.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: walk EXP MSB first; a set bit inserts a MUL after the SQR.
    // NOTE: state_nx is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start)      state_nx = SQR;
            SQR: begin
                if (EXP[idx])         state_nx = MUL;
                else if (idx == '0)   state_nx = DONE;
                else                  state_nx = SQR;
            end
            MUL: begin
                if (idx == '0)        state_nx = DONE;
                else                  state_nx = SQR;
            end
            DONE:                     state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, accumulator update, bit index and result latch.
    // The result is captured on the edge entering DONE so inv is already valid
    // while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r   <= '0;
            acc   <= '0;
            idx   <= '0;
            inv_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r   <= a_red;
                        acc   <= WIDTH'(1);
                        idx   <= IDX_HI;
                        err_q <= (a_red == '0);
                    end
                end
                SQR, MUL: begin
                    acc <= prod_red;
                    if (state_nx == SQR)  idx   <= idx - IW'(1);
                    if (state_nx == DONE) inv_q <= prod_red;
                end
                default: ;
            endcase
        end
    end

    // Output decode: busy while exponentiating, done for the single DONE cycle.
    always_comb begin
        bus.busy = (state == SQR) || (state == MUL);
        bus.done = (state == DONE);
    end

    assign bus.inv = inv_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_mod_inv.sv
// Self-checking bench for mod_inv: directed corner cases plus random operands
// compared against an extended-Euclid inverse model.
module tb_mod_inv;

    localparam int WIDTH = 13;
    localparam int Q     = 7681;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mod_inv_if #(.WIDTH(WIDTH)) bus ();

    mod_inv #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Modular inverse by the extended Euclidean algorithm; 0 for a zero residue.
    function automatic int inv_ref(input int x);
        int r0, r1, t0, t1, q, tmp;
        r0 = Q;
        r1 = x % Q;
        if (r1 == 0) return 0;
        t0 = 0;
        t1 = 1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
        end
        if (t0 < 0) t0 += Q;
        return t0;
    endfunction

    // Present a request and return #1 after the accepting edge.
    task automatic launch(input int val);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = WIDTH'(val);
        @(posedge clk);
        #1;
    endtask

    // Count edges until done is seen (bounded); optionally scramble inputs meanwhile.
    task automatic wait_done(input bit disturb, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.done && disturb) begin
                bus.start = 1'($urandom);
                bus.a     = WIDTH'($urandom);
            end
        end while (!bus.done && n < 80);
    endtask

    // One complete operation with latency, result, err and pulse-width checks.
    task automatic run_op(input int val, input bit disturb, input string tag);
        int n;
        launch(val);
        bus.start = 1'b0;
        wait_done(disturb, n);
        bus.start = 1'b0;
        check({tag, "_lat"}, n, 25);
        check({tag, "_inv"}, int'(bus.inv), inv_ref(val));
        check({tag, "_err"}, int'(bus.err), int'((val % Q) == 0));
        @(posedge clk);
        #1;
        check({tag, "_done_w"}, int'(bus.done), 0);
    endtask

    initial begin
        int n;
        int pulses;
        int v;
        int inv1;

        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_inv",  int'(bus.inv),  0);
        check("rst_err",  int'(bus.err),  0);
        @(negedge clk);
        rst = 1'b1;

        // Directed values.
        run_op(1,    1'b0, "a1");
        run_op(2,    1'b0, "a2");
        check("a2_const", int'(bus.inv), 3841);
        run_op(3,    1'b0, "a3");
        check("a3_const", int'(bus.inv), 5121);
        run_op(7680, 1'b0, "a7680");
        run_op(7682, 1'b0, "a7682");
        check("a7682_const", int'(bus.inv), 1);
        run_op(0,    1'b0, "a0");
        check("a0_err_const", int'(bus.err), 1);
        run_op(7681, 1'b0, "a7681");
        run_op(5,    1'b0, "a5");

        // Reset mid-operation: outputs clear, no done pulse afterwards.
        launch(1234);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("arst_done", int'(bus.done), 0);
        check("arst_inv",  int'(bus.inv),  0);
        check("arst_err",  int'(bus.err),  0);
        rst    = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("arst_no_done", pulses, 0);

        // start held high: back-to-back operations 27 cycles apart.
        launch(4592);
        wait_done(1'b0, n);
        check("hold1_lat", n, 25);
        inv1 = int'(bus.inv);
        check("hold1_inv", inv1, inv_ref(4592));
        check("hold1_prod", (inv1 * 4592) % Q, 1);
        bus.a = WIDTH'(5623);
        wait_done(1'b0, n);
        bus.start = 1'b0;
        check("hold_period", n, 27);
        check("hold2_inv", int'(bus.inv), inv_ref(5623));
        check("hold2_prod", (int'(bus.inv) * 5623) % Q, 1);
        @(posedge clk);
        #1;
        check("hold2_done_w", int'(bus.done), 0);
        repeat (3) @(posedge clk);

        // Inputs scrambled while busy must not disturb result or timing.
        run_op(100,  1'b1, "dist100");
        run_op(4000, 1'b1, "dist4000");

        // Random operands over the full input range.
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 8191));
            run_op(v, 1'b0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
